core_sequencer: RTL and testbench

Multi-cycle control FSM for the single-issue RV32I core. It fetches each instruction over a request/valid instruction-memory handshake and decodes R-type, I-type ALU, LW and SW. It drives the registered ALU/regfile controls to the datapath, runs the data-memory handshake for loads and stores, and advances the PC. It sits between the instruction/data memory ports and the ALU/register-file datapath.

---
 rtl/core_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_core_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the RV32I core.
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt instead of executing as NOPs.
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    output logic [31:0] instr,
    output logic [3:0]  aluop,
    output logic        sel_b,
    output logic        imm_s,
    output logic        sel_wb,
    output logic [31:0] wb_data,
    output logic        rf_en,
    output logic [31:0] pc,
    output logic        halt,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    localparam logic [6:0]  OPC_R    = 7'b0110011;
    localparam logic [6:0]  OPC_I    = 7'b0010011;
    localparam logic [6:0]  OPC_LW   = 7'b0000011;
    localparam logic [6:0]  OPC_SW   = 7'b0100011;
    localparam logic [6:0]  F7_ZERO  = 7'b0000000;
    localparam logic [6:0]  F7_ALT   = 7'b0100000;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic        is_ld;
    logic        is_st;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  base_op;
    logic [3:0]  alt_op;
    logic [3:0]  dec_op;
    logic        dec_selb;
    logic        dec_imms;
    logic        dec_selwb;
    logic        dec_ld;
    logic        dec_st;
    logic        dec_ok;
    logic        timeout;
    logic        pc_inc;
    logic        go_fault;

    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        base_op = 4'b0000;
        unique case (f3)
            3'b000: base_op = 4'b0000;
            3'b001: base_op = 4'b0010;
            3'b010: base_op = 4'b0011;
            3'b011: base_op = 4'b0100;
            3'b100: base_op = 4'b0101;
            3'b101: base_op = 4'b0110;
            3'b110: base_op = 4'b1000;
            3'b111: base_op = 4'b1001;
            default: base_op = 4'b0000;
        endcase
        alt_op = (f3 == 3'b101) ? 4'b0111 : 4'b0001;
    end

    always_comb begin
        dec_op    = 4'b0000;
        dec_selb  = 1'b0;
        dec_imms  = 1'b0;
        dec_selwb = 1'b0;
        dec_ld    = 1'b0;
        dec_st    = 1'b0;
        dec_ok    = 1'b0;
        unique case (1'b1)
            instr[6:0] == OPC_R: begin
                dec_ok = (f7 == F7_ZERO) ||
                         (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                dec_op = (f7 == F7_ALT) ? alt_op : base_op;
            end
            instr[6:0] == OPC_I: begin
                dec_selb = 1'b1;
                // Only the shift-immediates carry a funct7 field
                if (f3 == 3'b001) begin
                    dec_ok = (f7 == F7_ZERO);
                    dec_op = base_op;
                end else if (f3 == 3'b101) begin
                    dec_ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    dec_op = (f7 == F7_ALT) ? alt_op : base_op;
                end else begin
                    dec_ok = 1'b1;
                    dec_op = base_op;
                end
            end
            instr[6:0] == OPC_LW: begin
                dec_ok    = (f3 == 3'b010);
                dec_selb  = 1'b1;
                dec_selwb = 1'b1;
                dec_ld    = 1'b1;
            end
            instr[6:0] == OPC_SW: begin
                dec_ok   = (f3 == 3'b010);
                dec_selb = 1'b1;
                dec_imms = 1'b1;
                dec_st   = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        timeout    = (wait_cnt == TMO_LAST);
        pc_inc     = 1'b0;
        go_fault   = 1'b0;
        unique case (state)
            ST_RST: next_state = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    next_state = ST_DECODE;
                end else if (timeout) begin
                    next_state = ST_HALT;
                    go_fault   = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_ok) begin
                    next_state = ST_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = ST_HALT;
`else
                    next_state = ST_FETCH;
                    pc_inc     = 1'b1;
`endif
                end
            end
            ST_EXEC: next_state = (is_ld || is_st) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_valid) begin
                    next_state = is_st ? ST_FETCH : ST_WB;
                    pc_inc     = is_st;
                end else if (timeout) begin
                    next_state = ST_HALT;
                    go_fault   = 1'b1;
                end
            end
            ST_WB: begin
                next_state = ST_FETCH;
                pc_inc     = 1'b1;
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST;
            wait_cnt <= 16'd0;
            halt     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == ST_FETCH && !imem_valid) ||
                (state == ST_MEM && !dmem_valid))
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= 16'd0;
            if (next_state == ST_HALT)
                halt <= 1'b1;
            if (go_fault)
                fault <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= 32'h0;
            aluop      <= 4'h0;
            sel_b      <= 1'b0;
            imm_s      <= 1'b0;
            sel_wb     <= 1'b0;
            is_ld      <= 1'b0;
            is_st      <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            wb_data    <= 32'h0;
        end else begin
            if (state == ST_FETCH && imem_valid)
                instr <= imem_rdata;
            if (state == ST_DECODE && dec_ok) begin
                aluop  <= dec_op;
                sel_b  <= dec_selb;
                imm_s  <= dec_imms;
                sel_wb <= dec_selwb;
                is_ld  <= dec_ld;
                is_st  <= dec_st;
            end
            if (state == ST_EXEC && (is_ld || is_st)) begin
                dmem_addr  <= alu_result;
                dmem_wdata <= rs2_data;
            end
            if (state == ST_MEM && dmem_valid && is_ld)
                wb_data <= dmem_rdata;
            if (pc_inc)
                pc <= pc + 32'd4;
        end
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == ST_MEM);
    assign dmem_we   = (state == ST_MEM) && is_st;
    assign rf_en     = (state == ST_WB) && (instr[11:7] != 5'd0);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: ALU, load, store, timeout,
// reset-abort and illegal-instruction cases against hand-computed values.
module tb_core_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [31:0] instr;
    logic [3:0]  aluop;
    logic        sel_b;
    logic        imm_s;
    logic        sel_wb;
    logic [31:0] wb_data;
    logic        rf_en;
    logic [31:0] pc;
    logic        halt;
    logic        fault;

    logic [31:0] prog [0:15];
    int          iwait;
    int          dwait;
    int          icnt;
    int          dcnt;
    int          total;
    int          bad;
    int          cyc;
    int          rf_cnt;
    int          rf_cyc;

    core_sequencer u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
        .alu_result(alu_result), .rs2_data(rs2_data),
        .instr(instr), .aluop(aluop), .sel_b(sel_b), .imm_s(imm_s),
        .sel_wb(sel_wb), .wb_data(wb_data), .rf_en(rf_en), .pc(pc),
        .halt(halt), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: valid after a programmable number of wait cycles
    assign imem_rdata = prog[imem_addr[5:2]];
    assign imem_valid = imem_req && (icnt == iwait);
    assign dmem_valid = dmem_req && (dcnt == dwait);

    always @(posedge clk) begin
        if (imem_req && !imem_valid) icnt <= icnt + 1;
        else icnt <= 0;
        if (dmem_req && !dmem_valid) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rf_en) begin
                rf_cnt++;
                rf_cyc = cyc;
            end
        end
    endtask

    task automatic load_prog(input logic [31:0] i0, input logic [31:0] i1);
        for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0013;
        prog[0] = i0;
        prog[1] = i1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step(2);
        rst_n  = 1'b1;
        cyc    = 0;
        rf_cnt = 0;
        rf_cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cyc = 0; rf_cnt = 0; rf_cyc = 0;
        icnt = 0; dcnt = 0; iwait = 0; dwait = 0;
        rst_n = 1'b0;
        alu_result = 32'h0;
        rs2_data   = 32'h0;
        dmem_rdata = 32'hDEAD_BEEF;
        load_prog(32'h0050_0093, 32'h0000_0013);
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_aluop", 32'(aluop), 32'h0);
        chk("rst_ctl", {sel_b, imm_s, sel_wb, rf_en}, 32'h0);
        chk("rst_req", {imem_req, dmem_req, dmem_we}, 32'h0);
        chk("rst_hf", {halt, fault}, 32'h0);
        chk("rst_dm", dmem_addr | dmem_wdata | wb_data, 32'h0);

        // ADDI x1,x0,5
        do_reset;
        step(1);
        chk("addi_req", 32'(imem_req), 32'h1);
        chk("addi_addr", imem_addr, 32'h0);
        step(2);
        chk("addi_aluop", 32'(aluop), 32'h0);
        chk("addi_selb", 32'(sel_b), 32'h1);
        step(1);
        chk("addi_rfen4", 32'(rf_en), 32'h1);
        step(1);
        chk("addi_pc", pc, 32'h4);
        chk("addi_rfcnt", 32'(rf_cnt), 32'h1);
        chk("addi_rfcyc", 32'(rf_cyc), 32'h4);

        // SUB x3,x1,x2 then ADD x3,x1,x2
        load_prog(32'h4020_81B3, 32'h0020_81B3);
        do_reset;
        step(3);
        chk("sub_aluop", 32'(aluop), 32'h1);
        chk("sub_selb", 32'(sel_b), 32'h0);
        step(4);
        chk("add_aluop", 32'(aluop), 32'h0);
        step(2);
        chk("ra_pc", pc, 32'h8);
        chk("ra_rfcnt", 32'(rf_cnt), 32'h2);
        chk("ra_rfcyc", 32'(rf_cyc), 32'h8);

        // LW x5,8(x0) with two data wait cycles
        load_prog(32'h0080_2283, 32'h0000_0013);
        alu_result = 32'h8;
        dwait = 2;
        do_reset;
        step(3);
        chk("lw_selwb", 32'(sel_wb), 32'h1);
        step(1);
        chk("lw_req", {dmem_req, dmem_we}, 32'h2);
        chk("lw_addr", dmem_addr, 32'h8);
        step(3);
        chk("lw_wbdata", wb_data, 32'hDEAD_BEEF);
        chk("lw_rfen7", 32'(rf_en), 32'h1);
        step(1);
        chk("lw_pc", pc, 32'h4);
        chk("lw_rfcyc", 32'(rf_cyc), 32'h7);
        chk("lw_dreq_off", 32'(dmem_req), 32'h0);

        // SW x5,12(x0), zero-wait
        load_prog(32'h0050_2623, 32'h0000_0013);
        alu_result = 32'hC;
        rs2_data   = 32'h1234;
        dwait = 0;
        do_reset;
        step(4);
        chk("sw_we", {dmem_req, dmem_we}, 32'h3);
        chk("sw_addr", dmem_addr, 32'hC);
        chk("sw_wdata", dmem_wdata, 32'h1234);
        chk("sw_imms", 32'(imm_s), 32'h1);
        step(1);
        chk("sw_pc", pc, 32'h4);
        chk("sw_rfcnt", 32'(rf_cnt), 32'h0);

        // Store abandoned by reset while waiting in MEM
        dwait = 100;
        do_reset;
        step(4);
        chk("abort_req", 32'(dmem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_drop", {dmem_req, dmem_we}, 32'h0);
        chk("abort_addr", dmem_addr, 32'h0);
        chk("abort_pc", pc, 32'h0);
        dwait = 0;

        // Fetch never completes: timeout after 16 FETCH cycles
        alu_result = 32'h0;
        load_prog(32'h0050_0093, 32'h0000_0013);
        iwait = 1000;
        do_reset;
        step(16);
        chk("to_req16", {imem_req, halt}, 32'h2);
        step(1);
        chk("to_hf", {halt, fault}, 32'h3);
        chk("to_req", 32'(imem_req), 32'h0);
        chk("to_pc", pc, 32'h0);
        step(3);
        chk("to_sticky", {halt, fault, imem_req}, 32'h6);
        rst_n = 1'b0;
        #1;
        chk("to_rst", {halt, fault}, 32'h0);
        chk("to_rst_pc", pc, 32'h0);

        // Valid on the same edge as the timeout: valid wins
        iwait = 15;
        do_reset;
        step(17);
        chk("vw_halt", {halt, fault}, 32'h0);
        chk("vw_instr", instr, 32'h0050_0093);
        iwait = 0;

        // All-zero word is illegal
        load_prog(32'h0000_0000, 32'h0050_0093);
        do_reset;
        step(3);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_hf", {halt, fault}, 32'h2);
        chk("ill_pc", pc, 32'h0);
        chk("ill_req", 32'(imem_req), 32'h0);
`else
        chk("ill_pc", pc, 32'h4);
        chk("ill_req", {imem_req, halt}, 32'h2);
        chk("ill_rfcnt", 32'(rf_cnt), 32'h0);
        step(3);
        chk("ill_next_rf", 32'(rf_en), 32'h1);
        step(1);
        chk("ill_next_pc", pc, 32'h8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
